// File: rtl/cordic_vectoring_atan2.sv
// Iterative vectoring-mode CORDIC: atan2(Yin,Xin) in 32-bit turn format plus vector magnitude.
// Optional macro GAIN_COMP_EN adds a one-cycle GAIN state that scales the magnitude by 1/K.
module cordic_vectoring_atan2 #(
  parameter int c_parameter = 16,
  parameter int ITER        = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [c_parameter-1:0] Xin,
  input  logic signed [c_parameter-1:0] Yin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   angle_out,
  output logic [c_parameter:0]          mag_out,
  output logic                          zero_flag
);

  localparam int W = c_parameter + 2;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_GAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_stateNext;

  logic signed [W-1:0]   r_x;
  logic signed [W-1:0]   r_y;
  logic [31:0]           r_z;
  logic [4:0]            r_i;
  logic                  r_zero;
  logic [31:0]           r_angle;
  logic [c_parameter:0]  r_mag;
  logic                  r_zeroOut;

  logic signed [W-1:0]   w_xExt;
  logic signed [W-1:0]   w_yExt;
  logic signed [W-1:0]   w_xShift;
  logic signed [W-1:0]   w_yShift;
  logic signed [W-1:0]   w_xNext;
  logic signed [W-1:0]   w_yNext;
  logic [31:0]           w_zNext;
  logic [31:0]           w_atan;
  logic                  w_yNeg;
  logic                  w_lastStep;

  // Sign-extend before negating so that -(-2^(c_parameter-1)) stays representable.
  assign w_xExt     = {{2{Xin[c_parameter-1]}}, Xin};
  assign w_yExt     = {{2{Yin[c_parameter-1]}}, Yin};
  assign w_xShift   = r_x >>> r_i;
  assign w_yShift   = r_y >>> r_i;
  assign w_yNeg     = r_y[W-1];
  assign w_xNext    = w_yNeg ? (r_x - w_yShift) : (r_x + w_yShift);
  assign w_yNext    = w_yNeg ? (r_y + w_xShift) : (r_y - w_xShift);
  assign w_zNext    = w_yNeg ? (r_z - w_atan) : (r_z + w_atan);
  assign w_lastStep = (r_i == 5'(ITER - 1));

  // atan(2^-i) scaled so that 2^32 is one full turn.
  always_comb begin
    w_atan = 32'h0;
    case (r_i)
      5'd0:  w_atan = 32'h2000_0000;
      5'd1:  w_atan = 32'h12E4_051E;
      5'd2:  w_atan = 32'h09FB_385B;
      5'd3:  w_atan = 32'h0511_11D4;
      5'd4:  w_atan = 32'h028B_0D43;
      5'd5:  w_atan = 32'h0145_D7E1;
      5'd6:  w_atan = 32'h00A2_F61E;
      5'd7:  w_atan = 32'h0051_7C55;
      5'd8:  w_atan = 32'h0028_BE53;
      5'd9:  w_atan = 32'h0014_5F2F;
      5'd10: w_atan = 32'h000A_2F98;
      5'd11: w_atan = 32'h0005_17CC;
      5'd12: w_atan = 32'h0002_8BE6;
      5'd13: w_atan = 32'h0001_45F3;
      5'd14: w_atan = 32'h0000_A2FA;
      5'd15: w_atan = 32'h0000_517D;
      5'd16: w_atan = 32'h0000_28BE;
      5'd17: w_atan = 32'h0000_145F;
      5'd18: w_atan = 32'h0000_0A30;
      5'd19: w_atan = 32'h0000_0518;
      5'd20: w_atan = 32'h0000_028C;
      5'd21: w_atan = 32'h0000_0146;
      5'd22: w_atan = 32'h0000_00A3;
      5'd23: w_atan = 32'h0000_0051;
      5'd24: w_atan = 32'h0000_0029;
      5'd25: w_atan = 32'h0000_0014;
      5'd26: w_atan = 32'h0000_000A;
      5'd27: w_atan = 32'h0000_0005;
      5'd28: w_atan = 32'h0000_0003;
      5'd29: w_atan = 32'h0000_0001;
      default: w_atan = 32'h0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_stateNext = S_ITER;
      end
      S_ITER: begin
        if (w_lastStep) begin
`ifdef GAIN_COMP_EN
          w_stateNext = S_GAIN;
`else
          w_stateNext = S_DONE;
`endif
        end
      end
      S_GAIN: w_stateNext = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

`ifdef GAIN_COMP_EN
  logic [W+15:0] w_product;
  assign w_product = $unsigned(r_x) * 16'h9B75;
`endif

  // Result registers are loaded only when a sample finishes, so they hold steady through DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_i       <= '0;
      r_zero    <= 1'b0;
      r_angle   <= '0;
      r_mag     <= '0;
      r_zeroOut <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_i    <= '0;
            r_zero <= (Xin == '0) && (Yin == '0);
            if (!Xin[c_parameter-1]) begin
              r_x <= w_xExt;
              r_y <= w_yExt;
              r_z <= 32'h0000_0000;
            end else if (!Yin[c_parameter-1]) begin
              r_x <= w_yExt;
              r_y <= -w_xExt;
              r_z <= 32'h4000_0000;
            end else begin
              r_x <= -w_yExt;
              r_y <= w_xExt;
              r_z <= 32'hC000_0000;
            end
          end
        end
        S_ITER: begin
          r_x <= w_xNext;
          r_y <= w_yNext;
          r_z <= w_zNext;
          r_i <= r_i + 5'd1;
`ifndef GAIN_COMP_EN
          if (w_lastStep) begin
            r_angle   <= r_zero ? 32'h0 : w_zNext;
            r_mag     <= r_zero ? '0 : w_xNext[c_parameter:0];
            r_zeroOut <= r_zero;
          end
`endif
        end
`ifdef GAIN_COMP_EN
        S_GAIN: begin
          r_angle   <= r_zero ? 32'h0 : r_z;
          r_mag     <= r_zero ? '0 : (c_parameter+1)'(w_product >> 16);
          r_zeroOut <= r_zero;
        end
`endif
        default: ;
      endcase
    end
  end

  assign angle_out = r_angle;
  assign mag_out   = r_mag;
  assign zero_flag = r_zeroOut;

endmodule

// File: tb/tb_cordic_vectoring_atan2.sv
// Directed-vector bench for cordic_vectoring_atan2 (c_parameter=16, ITER=16).
// Expected angles/magnitudes are hand-computed; GAIN_COMP_EN selects the compensated magnitudes.
module tb_cordic_vectoring_atan2;

  localparam int CW    = 16;
  localparam int NITER = 16;
`ifdef GAIN_COMP_EN
  localparam int LAT   = NITER + 1;
`else
  localparam int LAT   = NITER;
`endif
  localparam int PERIOD = LAT + 2;
  localparam int ATOL   = 65536;
  localparam int MTOL   = 4;

  logic                 clock;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [CW-1:0] Xin;
  logic signed [CW-1:0] Yin;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          angle_out;
  logic [CW:0]          mag_out;
  logic                 zero_flag;

  int compared;
  int mismatched;

  cordic_vectoring_atan2 #(.c_parameter(CW), .ITER(NITER)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Xin       (Xin),
    .Yin       (Yin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle_out (angle_out),
    .mag_out   (mag_out),
    .zero_flag (zero_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Xin = '0; Yin = '0;
    tick(); tick();
    compared += 5;
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    if (angle_out !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_angle got %h want 0", angle_out); end
    if (mag_out !== '0) begin mismatched++; $display("[TB] FAIL reset_mag got %0d want 0", mag_out); end
    if (zero_flag !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_zero got %b want 0", zero_flag); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_vectors();
    int vx[9]  = '{16384, 0, -16384, -16384, -32768, 0, 16384, 0, -16384};
    int vy[9]  = '{0, 16384, 0, -16384, -32768, 0, 16384, -16384, 16384};
    logic [31:0] va[9] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hA000_0000,
                           32'hA000_0000, 32'h0000_0000, 32'h2000_0000, 32'hC000_0000,
                           32'h6000_0000};
`ifdef GAIN_COMP_EN
    int vm[9]  = '{16384, 16384, 16384, 23170, 46341, 0, 23170, 16384, 23170};
`else
    int vm[9]  = '{26981, 26981, 26981, 38157, 76314, 0, 38157, 26981, 38157};
`endif
    for (int k = 0; k < 9; k++) begin
      int lat;
      int atol;
      int mtol;
      int mdiff;
      logic signed [31:0] adiff;
      logic wantZero;
      wantZero = (vx[k] == 0) && (vy[k] == 0);
      atol = wantZero ? 0 : ATOL;
      mtol = wantZero ? 0 : MTOL;
      Xin = CW'(vx[k]); Yin = CW'(vy[k]); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin tick(); lat++; end
      compared += 4;
      if (lat !== LAT) begin
        mismatched++; $display("[TB] FAIL latency vec%0d got %0d want %0d", k, lat, LAT);
      end
      adiff = angle_out - va[k];
      if (adiff > atol || adiff < -atol) begin
        mismatched++; $display("[TB] FAIL angle vec%0d got %h want %h", k, angle_out, va[k]);
      end
      mdiff = int'(mag_out) - vm[k];
      if (mdiff > mtol || mdiff < -mtol) begin
        mismatched++; $display("[TB] FAIL mag vec%0d got %0d want %0d", k, mag_out, vm[k]);
      end
      if (zero_flag !== wantZero) begin
        mismatched++; $display("[TB] FAIL zero_flag vec%0d got %b want %b", k, zero_flag, wantZero);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      compared += 2;
      if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL release_valid vec%0d got %b want 0", k, out_valid); end
      if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL release_ready vec%0d got %b want 1", k, in_ready); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] saveAngle;
    logic [CW:0] saveMag;
    int n;
    int bad;
    Xin = 16'sd16384; Yin = 16'sd16384; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    compared++;
    if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_timeout got %b want 1", out_valid); end
    saveAngle = angle_out;
    saveMag = mag_out;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || angle_out !== saveAngle || mag_out !== saveMag) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("[TB] FAIL hold_stable got %0d unstable cycles want 0 (valid=%b ready=%b angle=%h mag=%0d)",
               bad, out_valid, in_ready, angle_out, mag_out);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_ignore_in_valid();
    int n;
    logic signed [31:0] adiff;
    Xin = 16'sd0; Yin = 16'sd16384; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    Xin = 16'sd16384; Yin = 16'sd0; in_valid = 1'b1;
    compared++;
    if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL busy_in_ready got %b want 0", in_ready); end
    tick(); tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    adiff = angle_out - 32'h4000_0000;
    compared++;
    if (adiff > ATOL || adiff < -ATOL) begin
      mismatched++; $display("[TB] FAIL busy_angle got %h want %h", angle_out, 32'h4000_0000);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick(); tick();
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL busy_no_restart got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    Xin = -16'sd16384; Yin = -16'sd16384; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared += 2;
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_ready got %b want 1", in_ready); end
    if (angle_out !== 32'h0) begin mismatched++; $display("[TB] FAIL midreset_angle got %h want 0", angle_out); end
    seen = 0;
    for (int c = 0; c < NITER + 8; c++) begin
      if (out_valid) seen++;
      tick();
    end
    compared++;
    if (seen != 0) begin mismatched++; $display("[TB] FAIL midreset_valid got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int results;
    int n;
    logic signed [31:0] adiff;
    Xin = 16'sd16384; Yin = 16'sd0; in_valid = 1'b1; out_ready = 1'b1;
    results = 0;
    for (int e = 0; e < 3 * PERIOD; e++) begin
      if (in_ready) acc.push_back(e);
      if (out_valid) begin
        results++;
        adiff = angle_out;
        compared++;
        if (adiff > ATOL || adiff < -ATOL) begin
          mismatched++; $display("[TB] FAIL b2b_angle got %h want 0", angle_out);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    out_ready = 1'b0;
    compared += 2;
    if (acc.size() < 3) begin
      mismatched++; $display("[TB] FAIL b2b_accepts got %0d want >=3", acc.size());
    end else if (acc[1] - acc[0] != PERIOD || acc[2] - acc[1] != PERIOD) begin
      mismatched++; $display("[TB] FAIL b2b_period got %0d,%0d want %0d", acc[1] - acc[0], acc[2] - acc[1], PERIOD);
    end
    if (results < 2) begin
      mismatched++; $display("[TB] FAIL b2b_results got %0d want >=2", results);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_vectors();
    test_hold();
    test_ignore_in_valid();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
